bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 16, SHALL set the minimum number of granted cycles before an owner can be preempted; legal range 2..2^CNT_W-1.
REQ-002 Parameter CNT_W, default 5, SHALL set the width of the hold counter.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit, SHALL be the reset; asynchronous and active-high.
REQ-005 Port cpu_req, input, 1 bit, SHALL be the CPU's level-held request for the memory bus.
REQ-006 Port fpu_req, input, 1 bit, SHALL be the FPU's level-held request for the memory bus.
REQ-007 Port cpu_grant, output, 1 bit, SHALL indicate the CPU owns the bus (registered).
REQ-008 Port fpu_grant, output, 1 bit, SHALL indicate the FPU owns the bus (registered).
REQ-009 Port bus_control, output, 1 bit, SHALL be the memory-bus mux select (0 = CPU path, 1 = FPU path) (registered).
REQ-010 Port bus_busy, output, 1 bit, SHALL equal cpu_grant OR fpu_grant.

Function
REQ-011 The FSM SHALL have four states: IDLE, CPU_OWN, FPU_OWN, TURN.
REQ-012 An internal last_owner bit SHALL record the most recent owner (0 = CPU, 1 = FPU).
REQ-013 IDLE, only cpu_req high: next state SHALL be CPU_OWN.
REQ-014 IDLE, only fpu_req high: next state SHALL be FPU_OWN.
REQ-015 IDLE, both high: grant SHALL go to the requester that is not last_owner (round-robin).
REQ-016 IDLE, neither high: the FSM SHALL remain in IDLE.
REQ-017 Grant latency: a request sampled at edge k in IDLE SHALL show its grant high after edge k.
REQ-018 On entry to CPU_OWN or FPU_OWN: the hold counter SHALL load 0, and last_owner SHALL update to the new owner.
REQ-019 In an owner state: the hold counter SHALL increment each cycle, saturating at MAX_HOLD.
REQ-020 Release: owner req sampled low SHALL move the FSM to TURN.
REQ-021 Preemption: owner req high, other req high, and hold counter >= MAX_HOLD-1 SHALL move the FSM to TURN.
REQ-022 Owner req high with the other req low SHALL keep ownership indefinitely.
REQ-023 TURN SHALL last exactly one cycle with both grants low, then go to IDLE unconditionally.
REQ-024 Handover timing: owner drop sampled at edge k SHALL give TURN after k, IDLE after k+1, and the next grant after k+2.
REQ-025 cpu_grant SHALL be 1 only in CPU_OWN; fpu_grant SHALL be 1 only in FPU_OWN.
REQ-026 cpu_grant and fpu_grant SHALL never be 1 in the same cycle.
REQ-027 bus_control SHALL become 1 on entry to FPU_OWN and 0 on entry to CPU_OWN.
REQ-028 bus_control SHALL hold its value in IDLE and TURN, so the select never toggles while a grant is high.
REQ-029 bus_control SHALL change only on a cycle whose preceding cycle had both grants low.
REQ-030 A preempted owner that keeps req high SHALL re-request through IDLE under normal round-robin.
REQ-031 Requests arriving during TURN SHALL be evaluated only in IDLE and are not lost, because requests are level-held.

Reset
REQ-032 rst high SHALL immediately force:
- state = IDLE
- cpu_grant = 0, fpu_grant = 0, bus_busy = 0
- bus_control = 0
- last_owner = 1 (CPU wins the first simultaneous request)
- hold counter = 0
REQ-033 rst asserted mid-ownership SHALL drop the grant in the same cycle, without waiting for a clock edge.
REQ-034 Arbitration SHALL resume at the first clk edge after rst deasserts.

Verification (MAX_HOLD=4)
REQ-035 Simultaneous reset request: after rst, cpu_req=fpu_req=1 at edge 1 -> cpu_grant=1 and bus_control=0 after edge 1; fpu_grant stays 0.
REQ-036 Release and handover: CPU owns, fpu_req=1, cpu_req drops at edge 3 (before hold reaches 3) -> TURN after edge 3, IDLE after edge 4, fpu_grant=1 and bus_control=1 after edge 5.
REQ-037 Preemption: cpu_req and fpu_req held high -> cpu_grant high exactly 4 cycles, one TURN cycle, one IDLE cycle, then fpu_grant high 4 cycles; the pattern alternates.
REQ-038 No contender: fpu_req alone held 20 cycles -> fpu_grant high continuously; counter saturates at 4 with no preemption.
REQ-039 Async reset: rst pulsed between edges during FPU_OWN -> fpu_grant=0 and bus_control=0 before the next edge.
REQ-040 Assertion checks every cycle, random stimulus: never both grants high; bus_control constant whenever bus_busy=1.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master memory-bus arbiter (CPU/FPU) with round-robin tie-break,
// minimum-hold preemption and a one-cycle dead TURN cycle between owners.
module bus_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic cpu_req,
    input  logic fpu_req,
    output logic cpu_grant,
    output logic fpu_grant,
    output logic bus_control,
    output logic bus_busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_OWN = 2'd1,
        FPU_OWN = 2'd2,
        TURN    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_SAT = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_PRE = CNT_W'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             last_owner_q, last_owner_d;
    logic             cpu_grant_q, cpu_grant_d;
    logic             fpu_grant_q, fpu_grant_d;
    logic             bus_control_q, bus_control_d;
    logic [CNT_W-1:0] hold_inc;

    assign hold_inc = (hold_q < HOLD_SAT) ? hold_q + 1'b1 : hold_q;

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        last_owner_d  = last_owner_q;
        bus_control_d = bus_control_q;

        case (state_q)
            IDLE: begin
                if (cpu_req && fpu_req) begin
                    state_d = last_owner_q ? CPU_OWN : FPU_OWN;
                end else if (cpu_req) begin
                    state_d = CPU_OWN;
                end else if (fpu_req) begin
                    state_d = FPU_OWN;
                end
            end
            CPU_OWN: begin
                if (!cpu_req || (fpu_req && hold_q >= HOLD_PRE)) begin
                    state_d = TURN;
                end else begin
                    hold_d = hold_inc;
                end
            end
            FPU_OWN: begin
                if (!fpu_req || (cpu_req && hold_q >= HOLD_PRE)) begin
                    state_d = TURN;
                end else begin
                    hold_d = hold_inc;
                end
            end
            default: state_d = IDLE;
        endcase

        // Entry into an owner state is the only place the mux select may move,
        // and it always follows an IDLE cycle with both grants low.
        if (state_d == CPU_OWN && state_q != CPU_OWN) begin
            hold_d        = '0;
            last_owner_d  = 1'b0;
            bus_control_d = 1'b0;
        end else if (state_d == FPU_OWN && state_q != FPU_OWN) begin
            hold_d        = '0;
            last_owner_d  = 1'b1;
            bus_control_d = 1'b1;
        end

        cpu_grant_d = (state_d == CPU_OWN);
        fpu_grant_d = (state_d == FPU_OWN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            hold_q        <= '0;
            last_owner_q  <= 1'b1;
            cpu_grant_q   <= 1'b0;
            fpu_grant_q   <= 1'b0;
            bus_control_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_q        <= hold_d;
            last_owner_q  <= last_owner_d;
            cpu_grant_q   <= cpu_grant_d;
            fpu_grant_q   <= fpu_grant_d;
            bus_control_q <= bus_control_d;
        end
    end

    assign cpu_grant   = cpu_grant_q;
    assign fpu_grant   = fpu_grant_q;
    assign bus_control = bus_control_q;
    assign bus_busy    = cpu_grant_q | fpu_grant_q;

endmodule
